// File: rtl/local_mean_threshold.sv
// Adaptive-threshold front end: for every pixel, floor of the 3x3 clamped-window mean of the
// grayscale image, written in raster order to the threshold memory at one pixel per 11 clocks.
module local_mean_threshold #(
    parameter int WIDTH_BITS  = 7,
    parameter int HEIGHT_BITS = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oThresholdCol,
    output logic [HEIGHT_BITS-1:0] oThresholdRow,
    output logic [7:0]             oThresholdData,
    output logic                   oThresholdWren,
    output logic                   busy,
    output logic                   finished
);

    localparam logic [WIDTH_BITS-1:0]  COL_ONE = 1;
    localparam logic [WIDTH_BITS-1:0]  COL_MAX = '1;
    localparam logic [HEIGHT_BITS-1:0] ROW_ONE = 1;
    localparam logic [HEIGHT_BITS-1:0] ROW_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [WIDTH_BITS-1:0]   r_x;
    logic [HEIGHT_BITS-1:0]  r_y;
    logic [1:0]              r_dx;        // 0,1,2 encode dx = -1,0,+1
    logic [1:0]              r_dy;
    logic [11:0]             r_acc;
    logic                    r_busy;
    logic                    r_finished;

    logic [WIDTH_BITS-1:0]   w_tap_col;
    logic [HEIGHT_BITS-1:0]  w_tap_row;
    logic                    w_start;
    logic                    w_first_tap;
    logic                    w_last_tap;
    logic                    w_last_pixel;
    logic [23:0]             w_prod;
    logic [7:0]              w_quot;

    assign w_start      = iStart && !r_busy && (r_state == S_IDLE || r_state == S_DONE);
    assign w_first_tap  = (r_dx == 2'd0) && (r_dy == 2'd0);
    assign w_last_tap   = (r_dx == 2'd2) && (r_dy == 2'd2);
    assign w_last_pixel = (r_x == COL_MAX) && (r_y == ROW_MAX);

    // acc*7282>>16 equals floor(acc/9) for every acc up to 9*255.
    assign w_prod = {12'd0, r_acc} * 24'd7282;
    assign w_quot = 8'(w_prod >> 16);

    // Window taps clamp to the image border instead of reading outside it.
    always_comb begin
        w_tap_col = r_x;
        w_tap_row = r_y;
        if (r_dx == 2'd0 && r_x != '0)
            w_tap_col = r_x - COL_ONE;
        else if (r_dx == 2'd2 && r_x != COL_MAX)
            w_tap_col = r_x + COL_ONE;
        if (r_dy == 2'd0 && r_y != '0)
            w_tap_row = r_y - ROW_ONE;
        else if (r_dy == 2'd2 && r_y != ROW_MAX)
            w_tap_row = r_y + ROW_ONE;
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        w_next_state   = r_state;
        oImageCol      = '0;
        oImageRow      = '0;
        oThresholdCol  = '0;
        oThresholdRow  = '0;
        oThresholdData = '0;
        oThresholdWren = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start)
                    w_next_state = S_READ;
            end
            S_READ: begin
                oImageCol = w_tap_col;
                oImageRow = w_tap_row;
                if (w_last_tap)
                    w_next_state = S_LAST;
            end
            S_LAST: begin
                w_next_state = S_WRITE;
            end
            S_WRITE: begin
                oThresholdWren = 1'b1;
                oThresholdCol  = r_x;
                oThresholdRow  = r_y;
                oThresholdData = w_quot;
                w_next_state   = w_last_pixel ? S_DONE : S_READ;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start) begin
                        r_busy     <= 1'b1;
                        r_finished <= 1'b0;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_dx       <= '0;
                        r_dy       <= '0;
                        r_acc      <= '0;
                    end else if (r_state == S_DONE && r_busy) begin
                        // One retire cycle after the final write before reporting completion.
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                    end
                end
                S_READ: begin
                    if (!w_first_tap)
                        r_acc <= r_acc + {4'd0, iImageData};
                    if (w_last_tap) begin
                        r_dx <= '0;
                        r_dy <= '0;
                    end else if (r_dx == 2'd2) begin
                        r_dx <= '0;
                        r_dy <= r_dy + 2'd1;
                    end else begin
                        r_dx <= r_dx + 2'd1;
                    end
                end
                S_LAST: begin
                    r_acc <= r_acc + {4'd0, iImageData};
                end
                S_WRITE: begin
                    r_acc <= '0;
                    if (r_x == COL_MAX) begin
                        r_x <= '0;
                        r_y <= r_y + ROW_ONE;
                    end else begin
                        r_x <= r_x + COL_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign finished = r_finished;

endmodule

// File: tb/tb_local_mean_threshold.sv
// Self-checking bench for local_mean_threshold on an 8x8 frame with a 1-cycle-latency image memory
// and a clamped-window mean reference model.
module tb_local_mean_threshold;

    localparam int WB  = 3;
    localparam int HB  = 3;
    localparam int W   = 8;
    localparam int H   = 8;
    localparam int PIX = W * H;

    logic          clock = 1'b0;
    logic          reset;
    logic          iStart;
    logic [WB-1:0] oImageCol;
    logic [HB-1:0] oImageRow;
    logic [7:0]    iImageData;
    logic [WB-1:0] oThresholdCol;
    logic [HB-1:0] oThresholdRow;
    logic [7:0]    oThresholdData;
    logic          oThresholdWren;
    logic          busy;
    logic          finished;

    always #5 clock = ~clock;

    local_mean_threshold #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
        .clock          (clock),
        .reset          (reset),
        .iStart         (iStart),
        .oImageCol      (oImageCol),
        .oImageRow      (oImageRow),
        .iImageData     (iImageData),
        .oThresholdCol  (oThresholdCol),
        .oThresholdRow  (oThresholdRow),
        .oThresholdData (oThresholdData),
        .oThresholdWren (oThresholdWren),
        .busy           (busy),
        .finished       (finished)
    );

    logic [7:0] img [H][W];
    logic [7:0] mem_q = 8'd0;
    always @(posedge clock) mem_q <= img[oImageRow][oImageCol];
    assign iImageData = mem_q;

    int wr_col[$];
    int wr_row[$];
    int wr_dat[$];
    int got [H][W];

    always @(negedge clock) begin
        if (oThresholdWren) begin
            wr_col.push_back(int'(oThresholdCol));
            wr_row.push_back(int'(oThresholdRow));
            wr_dat.push_back(int'(oThresholdData));
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference: plain 3x3 clamped sum divided by 9.
    function automatic int ref_thr(input int x, input int y);
        int sum = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                sum += int'(img[clamp(y + dy, H - 1)][clamp(x + dx, W - 1)]);
        return sum / 9;
    endfunction

    task automatic fill(input int value);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'(value);
    endtask

    task automatic fill_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom_range(0, 255));
    endtask

    task automatic clear_log();
        wr_col.delete();
        wr_row.delete();
        wr_dat.delete();
    endtask

    // Pulse iStart so that it is sampled on exactly one rising edge; returns at the next falling edge.
    task automatic start_pulse();
        @(negedge clock);
        iStart = 1'b1;
        @(negedge clock);
        iStart = 1'b0;
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_wren"},  int'(oThresholdWren), 0);
        check({name, "_busy"},  int'(busy), 0);
        check({name, "_fin"},   int'(finished), 0);
        check({name, "_tdat"},  int'(oThresholdData), 0);
        check({name, "_tcol"},  int'(oThresholdCol), 0);
        check({name, "_trow"},  int'(oThresholdRow), 0);
        check({name, "_icol"},  int'(oImageCol), 0);
        check({name, "_irow"},  int'(oImageRow), 0);
    endtask

    // Runs one full pass; restart_at > 0 pulses iStart again that many edges into the pass.
    task automatic run_frame(input string name, input int restart_at);
        int n = 0;
        int cnt;
        clear_log();
        start_pulse();
        check({name, "_busy_start"}, int'(busy), 1);
        while (!finished && n < 2000) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            iStart = (restart_at > 0 && n == restart_at);
        end
        iStart = 1'b0;
        check({name, "_latency"}, n, 11 * PIX + 1);
        check({name, "_busy_end"}, int'(busy), 0);
        repeat (20) @(negedge clock);
        cnt = wr_col.size();
        check({name, "_nwrites"}, cnt, PIX);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                got[r][c] = -1;
        for (int i = 0; i < cnt && i < PIX; i++) begin
            check({name, "_col"}, wr_col[i], i % W);
            check({name, "_row"}, wr_row[i], i / W);
            check({name, "_thr"}, wr_dat[i], ref_thr(i % W, i / W));
            got[i / W][i % W] = wr_dat[i];
        end
        check({name, "_fin_held"}, int'(finished), 1);
    endtask

    initial begin
        int n_before;
        reset  = 1'b1;
        iStart = 1'b0;
        fill(0);
        repeat (3) @(negedge clock);
        check_idle_outputs("rst");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Uniform image, with a second start pulse while busy that must be ignored.
        fill(100);
        run_frame("uniform", 100);
        check("uniform_c34", got[4][3], 100);

        fill(0);
        img[5][5] = 8'd255;
        run_frame("spot55", 0);
        check("spot55_c44", got[4][4], 28);
        check("spot55_c66", got[6][6], 28);
        check("spot55_c37", got[7][3], 0);

        fill(0);
        img[0][0] = 8'd90;
        run_frame("corner00", 0);
        check("corner00_c00", got[0][0], 40);
        check("corner00_c10", got[0][1], 20);
        check("corner00_c01", got[1][0], 20);
        check("corner00_c11", got[1][1], 10);
        check("corner00_c22", got[2][2], 0);

        fill(0);
        img[7][7] = 8'd90;
        run_frame("corner77", 0);
        check("corner77_c77", got[7][7], 40);
        check("corner77_c66", got[6][6], 10);

        fill(255);
        run_frame("sat", 0);
        check("sat_c00", got[0][0], 255);
        check("sat_c44", got[4][4], 255);

        for (int k = 0; k < 2; k++) begin
            fill_random();
            run_frame("random", 0);
        end

        // Abort a pass with reset on its 300th edge, then restart cleanly.
        fill_random();
        clear_log();
        start_pulse();
        repeat (299) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_idle_outputs("abort");
        n_before = wr_col.size();
        check("abort_writes", n_before, 27);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (50) @(negedge clock);
        check("abort_no_more", wr_col.size(), n_before);
        check("abort_busy", int'(busy), 0);
        fill_random();
        run_frame("restart", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
